// File: rtl/cpu_regfile_pkg.sv
// Shared defaults and helper types for the CPU register file (width defaults used by
// the decode and writeback stages too).
package cpu_regfile_pkg;
   localparam int CPU_DATA_W     = 32;
   localparam int CPU_REG_ADDR_W = 5;

   // Where a read port takes its data from this cycle.
   typedef enum logic {
      RD_STORED = 1'b0,
      RD_BYPASS = 1'b1
   } rd_src_e;

   function automatic int num_bytes(int data_w);
      return data_w / 8;
   endfunction
endpackage

// File: rtl/cpu_regfile_if.sv
// Write port and two read ports of the register file; the writeback/decode side is master.
interface cpu_regfile_if
   import cpu_regfile_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int ADDR_W = CPU_REG_ADDR_W
) ();
   logic                             we;
   logic [ADDR_W-1:0]                waddr;
   logic [DATA_W-1:0]                wdata;
   logic [num_bytes(DATA_W)-1:0]     wbe;
   logic [ADDR_W-1:0]                raddr_a;
   logic [DATA_W-1:0]                rdata_a;
   logic [ADDR_W-1:0]                raddr_b;
   logic [DATA_W-1:0]                rdata_b;

   modport master (
      output we, waddr, wdata, wbe, raddr_a, raddr_b,
      input  rdata_a, rdata_b
   );

   modport slave (
      input  we, waddr, wdata, wbe, raddr_a, raddr_b,
      output rdata_a, rdata_b
   );
endinterface

// File: rtl/cpu_regfile_reg_cell.sv
// One DATA_W-wide register with per-byte write enables and a synchronous active-low
// reset to RST_VAL; reset wins over any byte enable.
module reg_cell
   import cpu_regfile_pkg::*;
#(
   parameter int                DATA_W  = CPU_DATA_W,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [num_bytes(DATA_W)-1:0] be_i,
   input  logic [DATA_W-1:0]            d_i,
   output logic [DATA_W-1:0]            q_o
);
   localparam int NB = num_bytes(DATA_W);

   logic [DATA_W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      for (int i = 0; i < NB; i++) begin
         if (be_i[i]) q_d[8*i +: 8] = d_i[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) q_q <= RST_VAL;
      else        q_q <= q_d;
   end

   assign q_o = q_q;
endmodule

// File: rtl/cpu_regfile.sv
// NUM_REGS x DATA_W register file: one byte-enabled synchronous write port, two
// combinational read ports. Define REGFILE_BYPASS_EN for same-cycle write-through.
module cpu_regfile
   import cpu_regfile_pkg::*;
#(
   parameter int                DATA_W    = CPU_DATA_W,
   parameter int                ADDR_W    = CPU_REG_ADDR_W,
   parameter bit                ZERO_REG0 = 1'b1,
   parameter logic [DATA_W-1:0] RST_VAL   = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   cpu_regfile_if.slave bus
);
   localparam int NUM_REGS = 2 ** ADDR_W;
   localparam int NB       = num_bytes(DATA_W);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   logic [DATA_W-1:0]               wr_merged;
   logic                            byp_a, byp_b;
   rd_src_e                         src_a, src_b;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      if (ZERO_REG0 && g == 0) begin : g_zero
         assign regs[g] = '0;
      end else begin : g_cell
         logic [NB-1:0] be;
         assign be = (bus.we && bus.waddr == ADDR_W'(g)) ? bus.wbe : '0;
         reg_cell #(
            .DATA_W (DATA_W),
            .RST_VAL(RST_VAL)
         ) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .be_i (be),
            .d_i  (bus.wdata),
            .q_o  (regs[g])
         );
      end
   end

   // Value reg[waddr] will hold after this edge; only ever selected by the bypass.
   always_comb begin
      wr_merged = regs[bus.waddr];
      for (int i = 0; i < NB; i++) begin
         if (bus.wbe[i]) wr_merged[8*i +: 8] = bus.wdata[8*i +: 8];
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic wr_live;
   assign wr_live = bus.we && rst_n && !(ZERO_REG0 && bus.waddr == '0);
   assign byp_a   = wr_live && (bus.raddr_a == bus.waddr);
   assign byp_b   = wr_live && (bus.raddr_b == bus.waddr);
`else
   assign byp_a = 1'b0;
   assign byp_b = 1'b0;
`endif

   assign src_a = byp_a ? RD_BYPASS : RD_STORED;
   assign src_b = byp_b ? RD_BYPASS : RD_STORED;

   assign bus.rdata_a = (src_a == RD_BYPASS) ? wr_merged : regs[bus.raddr_a];
   assign bus.rdata_b = (src_b == RD_BYPASS) ? wr_merged : regs[bus.raddr_b];
endmodule
